// File: rtl/braille_advance_if.sv
// Signal bundle between the chip-side button/config inputs and the advance sequencer outputs.
interface braille_advance_if #(
    parameter int unsigned DWELL_WIDTH = 16,
    parameter int unsigned IDX_WIDTH   = 5
);
    logic                   btn_raw;
    logic                   auto_en;
    logic [DWELL_WIDTH-1:0] dwell;
    logic [IDX_WIDTH-1:0]   msg_len;
    logic                   next_pulse;
    logic [IDX_WIDTH-1:0]   char_idx;
    logic                   wrap;
    logic                   btn_level;

    modport master (
        output btn_raw, auto_en, dwell, msg_len,
        input  next_pulse, char_idx, wrap, btn_level
    );

    modport slave (
        input  btn_raw, auto_en, dwell, msg_len,
        output next_pulse, char_idx, wrap, btn_level
    );
endinterface

// File: rtl/braille_advance_ctrl.sv
// Turns a bouncy push-button plus an optional dwell timer into single-cycle advance strobes
// and tracks the displayed character index with programmable wrap.
module braille_advance_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DWELL_WIDTH     = 16,
    parameter int unsigned IDX_WIDTH       = 5
) (
    input logic              clk,
    input logic              reset,
    braille_advance_if.slave bus
);
    localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {Released, PressWait, Pressed, ReleaseWait} db_state_e;

    db_state_e              state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   sync1_q, sync2_q;
    logic                   btn_level_q;
    logic [DWELL_WIDTH-1:0] timer_q;
    logic                   next_pulse_q, wrap_q;
    logic [IDX_WIDTH-1:0]   idx_q;

    logic                   manual_req, auto_req, adv_req, dwell_active, wrap_hit;
    logic [IDX_WIDTH:0]     idx_inc;

    always_comb begin
        // Request fires on the edge where the stable count would reach DEBOUNCE_CYCLES.
        manual_req   = (state_q == PressWait) && sync2_q && (cnt_q == CntLast);
        dwell_active = bus.auto_en && (bus.dwell != '0);
        auto_req     = dwell_active && (timer_q >= (bus.dwell - DWELL_WIDTH'(1)));
        adv_req      = manual_req || auto_req;
        idx_inc      = {1'b0, idx_q} + (IDX_WIDTH + 1)'(1);
        if (bus.msg_len != '0) begin
            wrap_hit = (idx_inc == {1'b0, bus.msg_len}) || (idx_q >= bus.msg_len);
        end else begin
            wrap_hit = (idx_q == '1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= Released;
            cnt_q       <= '0;
            btn_level_q <= 1'b0;
        end else begin
            case (state_q)
                Released: begin
                    if (sync2_q) begin
                        state_q <= PressWait;
                        cnt_q   <= CNT_WIDTH'(1);
                    end
                end
                PressWait: begin
                    if (!sync2_q) begin
                        state_q <= Released;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q     <= Pressed;
                        cnt_q       <= '0;
                        btn_level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                Pressed: begin
                    if (!sync2_q) begin
                        state_q <= ReleaseWait;
                        cnt_q   <= CNT_WIDTH'(1);
                    end
                end
                ReleaseWait: begin
                    if (sync2_q) begin
                        state_q <= Pressed;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q     <= Released;
                        cnt_q       <= '0;
                        btn_level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q     <= Released;
                    cnt_q       <= '0;
                    btn_level_q <= 1'b0;
                end
            endcase
        end
    end

    // A manual advance restarts the dwell period so the reader gets a full interval.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else if (!dwell_active || adv_req) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + DWELL_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_pulse_q <= 1'b0;
            wrap_q       <= 1'b0;
            idx_q        <= '0;
        end else begin
            next_pulse_q <= adv_req;
            wrap_q       <= adv_req && wrap_hit;
            if (adv_req) begin
                idx_q <= wrap_hit ? '0 : idx_inc[IDX_WIDTH-1:0];
            end
        end
    end

    assign bus.next_pulse = next_pulse_q;
    assign bus.wrap       = wrap_q;
    assign bus.char_idx   = idx_q;
    assign bus.btn_level  = btn_level_q;
endmodule

// File: tb/tb_braille_advance_ctrl.sv
// Directed bench for braille_advance_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_braille_advance_ctrl;
    localparam int DWELL_W = 16;
    localparam int IDX_W   = 5;

    typedef struct {
        int rst;
        int btn;
        int auto_en;
        int dwell;
        int len;
        int cyc;
        int np;
        int idx;
        int wrap;
        int lvl;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    braille_advance_if #(.DWELL_WIDTH(DWELL_W), .IDX_WIDTH(IDX_W)) bus ();

    braille_advance_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .DWELL_WIDTH    (DWELL_W),
        .IDX_WIDTH      (IDX_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int rst, input int btn, input int auto_en, input int dwell,
                           input int len, input int cyc, input int np, input int idx,
                           input int wrap, input int lvl);
        vecs.push_back('{rst, btn, auto_en, dwell, len, cyc, np, idx, wrap, lvl});
    endtask

    task automatic check_outs(input string tag, input int np, input int idx, input int wrap,
                              input int lvl);
        check({tag, ".next_pulse"}, 64'(bus.next_pulse), 64'(np));
        check({tag, ".char_idx"}, 64'(bus.char_idx), 64'(idx));
        check({tag, ".wrap"}, 64'(bus.wrap), 64'(wrap));
        check({tag, ".btn_level"}, 64'(bus.btn_level), 64'(lvl));
    endtask

    task automatic do_reset();
        bus.btn_raw = 1'b0;
        bus.auto_en = 1'b0;
        bus.dwell   = '0;
        bus.msg_len = '0;
        reset       = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] mask;
        int          bounce_pulses;
        vec_t        v;

        bus.btn_raw = 1'b0;
        bus.auto_en = 1'b0;
        bus.dwell   = '0;
        bus.msg_len = '0;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        check_outs("reset_state", 0, 0, 0, 0);

        // rst btn auto dwell len cyc | np idx wrap lvl
        add_vec(0, 1, 0, 0, 0, 17,  0, 0, 0, 0);   // still debouncing
        add_vec(0, 1, 0, 0, 0, 1,   1, 1, 0, 1);   // pulse 17 edges after first sample
        add_vec(0, 1, 0, 0, 0, 1,   0, 1, 0, 1);
        add_vec(0, 1, 0, 0, 0, 30,  0, 1, 0, 1);   // held: no repeat
        add_vec(0, 0, 0, 0, 0, 17,  0, 1, 0, 1);
        add_vec(0, 0, 0, 0, 0, 1,   0, 1, 0, 0);   // release accepted
        add_vec(1, 0, 0, 0, 0, 2,   0, 0, 0, 0);
        add_vec(0, 0, 1, 5, 3, 4,   0, 0, 0, 0);
        add_vec(0, 0, 1, 5, 3, 1,   1, 1, 0, 0);
        add_vec(0, 0, 1, 5, 3, 4,   0, 1, 0, 0);
        add_vec(0, 0, 1, 5, 3, 1,   1, 2, 0, 0);
        add_vec(0, 0, 1, 5, 3, 5,   1, 0, 1, 0);
        add_vec(0, 0, 1, 5, 3, 5,   1, 1, 0, 0);
        add_vec(0, 0, 1, 5, 3, 1,   0, 1, 0, 0);
        add_vec(0, 0, 1, 1, 0, 3,   1, 4, 0, 0);   // dwell=1: continuous
        add_vec(0, 0, 1, 20, 0, 10, 0, 4, 0, 0);
        add_vec(0, 0, 1, 3, 0, 1,   1, 5, 0, 0);   // dwell lowered below timer
        add_vec(0, 0, 0, 3, 0, 3,   0, 5, 0, 0);
        add_vec(0, 0, 1, 1, 10, 2,  1, 7, 0, 0);
        add_vec(0, 0, 0, 1, 10, 1,  0, 7, 0, 0);
        add_vec(0, 0, 0, 1, 4, 3,   0, 7, 0, 0);   // msg_len shrink: index untouched
        add_vec(0, 0, 1, 2, 4, 1,   0, 7, 0, 0);
        add_vec(0, 0, 1, 2, 4, 1,   1, 0, 1, 0);   // idx >= msg_len wraps
        add_vec(0, 0, 0, 2, 0, 1,   0, 0, 0, 0);
        add_vec(0, 0, 1, 1, 0, 31,  1, 31, 0, 0);
        add_vec(0, 0, 1, 1, 0, 1,   1, 0, 1, 0);   // full-range wrap 31->0
        add_vec(0, 0, 0, 1, 0, 1,   0, 0, 0, 0);

        foreach (vecs[i]) begin
            v           = vecs[i];
            reset       = v.rst[0];
            bus.btn_raw = v.btn[0];
            bus.auto_en = v.auto_en[0];
            bus.dwell   = DWELL_W'(v.dwell);
            bus.msg_len = IDX_W'(v.len);
            repeat (v.cyc) @(negedge clk);
            check_outs($sformatf("vec%0d", i), v.np, v.idx, v.wrap, v.lvl);
        end

        // Bounce: toggling every 3 cycles never debounces, final stable high pulses once.
        do_reset();
        bounce_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            bus.btn_raw = ((i / 3) % 2) == 0;
            @(negedge clk);
            if (bus.next_pulse) bounce_pulses++;
        end
        bus.btn_raw = 1'b1;
        mask = '0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (bus.next_pulse) mask[c] = 1'b1;
        end
        check("bounce_pulses", 64'(bounce_pulses), 64'd0);
        check("bounce_mask", mask, 64'd1 << 18);
        check("bounce_idx", 64'(bus.char_idx), 64'd1);

        // Collision: manual request lands on the auto terminal count at edge 20.
        do_reset();
        bus.auto_en = 1'b1;
        bus.dwell   = 16'd5;
        mask = '0;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            if (bus.next_pulse) mask[c] = 1'b1;
            if (c == 2) bus.btn_raw = 1'b1;
        end
        check("collision_mask", mask,
              (64'd1 << 5) | (64'd1 << 10) | (64'd1 << 15) | (64'd1 << 20) | (64'd1 << 25));
        check("collision_idx", 64'(bus.char_idx), 64'd5);

        // Manual request between auto pulses restarts the dwell period.
        do_reset();
        bus.auto_en = 1'b1;
        bus.dwell   = 16'd5;
        bus.btn_raw = 1'b1;
        mask = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.next_pulse) mask[c] = 1'b1;
        end
        check("restart_mask", mask,
              (64'd1 << 5) | (64'd1 << 10) | (64'd1 << 15) | (64'd1 << 18) | (64'd1 << 23) |
              (64'd1 << 28));
        check("restart_idx", 64'(bus.char_idx), 64'd6);

        // Reset mid-press with auto running; button held through release.
        do_reset();
        bus.auto_en = 1'b1;
        bus.dwell   = 16'd5;
        bus.btn_raw = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_reset_pulse", 64'(bus.next_pulse), 64'd1);
        check("pre_reset_idx", 64'(bus.char_idx), 64'd1);
        reset = 1'b1;
        #1;
        check_outs("async_reset", 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        bus.auto_en = 1'b0;
        reset       = 1'b0;
        mask = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.next_pulse) mask[c] = 1'b1;
        end
        check("held_reset_mask", mask, 64'd1 << 18);
        check("held_reset_idx", 64'(bus.char_idx), 64'd1);
        check("held_reset_level", 64'(bus.btn_level), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/braille_advance_ctrl.md
Name: braille_advance_ctrl

Overview:
- Sequencer that drives the braille converter's "next" input.
- Turns a raw, bouncy push-button into clean single-cycle advance pulses through a synchroniser, a debounce FSM and an edge detector.
- Adds an optional auto-advance (dwell) timer and tracks the current character index, wrapping at a programmable message length.
- Sits between the chip input pin and braille_converter_top's next port.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles needed to accept a level change (>=2)
DWELL_WIDTH, 16, width of the dwell period input and timer
IDX_WIDTH, 5, width of the character index

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
btn_raw  input  1  asynchronous push-button level, 1 = pressed
auto_en  input  1  1 = auto-advance enabled
dwell  input  DWELL_WIDTH  auto-advance period in cycles; 0 = auto-advance disabled
msg_len  input  IDX_WIDTH  characters in message; 0 = full 2^IDX_WIDTH range
next_pulse  output  1  one-cycle advance strobe to the converter
char_idx  output  IDX_WIDTH  index of the character currently displayed
wrap  output  1  one-cycle strobe, coincident with next_pulse when char_idx returns to 0
btn_level  output  1  debounced button level

Behaviour:
- Reset values: next_pulse=0, wrap=0, btn_level=0, char_idx=0, synchroniser flops=0, debounce count=0, dwell timer=0, FSM=RELEASED.
- Synchroniser: two flops, sync1 then sync2. Only sync2 is used downstream.
- Debounce FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED, sync2=1: go to PRESS_WAIT, count=1.
  - PRESS_WAIT, sync2=1: count increments. When count reaches DEBOUNCE_CYCLES, go to PRESSED and raise the manual request.
  - PRESS_WAIT, sync2=0: return to RELEASED, count=0.
  - PRESSED, sync2=0: go to RELEASE_WAIT, count=1.
  - RELEASE_WAIT, sync2=0: count increments. At DEBOUNCE_CYCLES, go to RELEASED.
  - RELEASE_WAIT, sync2=1: return to PRESSED.
  - btn_level=1 in PRESSED and RELEASE_WAIT.
- Manual latency: btn_raw is first sampled high at edge k and held. next_pulse is high for exactly the cycle following edge k+DEBOUNCE_CYCLES+1.
- A held button produces one pulse only; no auto-repeat.
- Dwell timer:
  - Active when auto_en=1 and dwell!=0. Otherwise it is held at 0.
  - Increments every cycle. When timer >= dwell-1, it raises an auto request and reloads to 0.
  - Lowering dwell below the current timer value fires at the next edge.
  - Pulses are spaced exactly dwell cycles apart. The first pulse comes dwell cycles after auto_en is first sampled high.
- Manual request clears the timer to 0, restarting the dwell period.
- Simultaneous manual and auto requests in the same cycle produce a single next_pulse.
- next_pulse is registered: high the cycle after a request, never two consecutive cycles unless dwell=1 (dwell=1 gives next_pulse high continuously).
- Index: on the same edge that sets next_pulse, char_idx updates.
  - char_idx becomes 0 and wrap=1 if char_idx+1 == msg_len, or char_idx >= msg_len (msg_len!=0).
  - char_idx becomes 0 and wrap=1 if char_idx == all-ones (msg_len==0).
  - Otherwise char_idx+1.
- msg_len changes take effect on the next advance only; char_idx is not modified until then.
- Reset asserted mid-operation clears everything immediately, asynchronously.
- A button held through reset release is treated as a fresh press: one pulse after debounce.

Test Plan:
- Clean press, DEBOUNCE_CYCLES=16, btn_raw held high from edge 10 -> single next_pulse in the cycle after edge 27, char_idx 0->1, btn_level=1, no further pulses while held.
- Bounce: btn_raw toggles every 3 cycles for 40 cycles, then stable high -> no pulse during bounce, exactly one pulse 17 edges after the last rising toggle.
- Auto: auto_en=1, dwell=5, msg_len=3 -> pulses every 5 cycles, char_idx 1,2,0,1; wrap high with the third pulse only.
- Collision: manual request and auto terminal count in the same cycle -> one pulse, char_idx +1, timer restarts, next auto pulse 5 cycles later.
- msg_len reduced from 10 to 4 while char_idx=7 -> next advance gives char_idx=0 and wrap=1. msg_len=0 with IDX_WIDTH=5 -> wraps 31->0.
- Reset asserted mid-PRESS_WAIT with auto running -> all outputs 0 immediately. Button still held after release -> one pulse after 17 edges.
